pack_scheduler: RTL and testbench

PACK_SCHEDULER -- requirements
Module: pack_scheduler

---
 rtl/pack_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_pack_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pack_scheduler.sv
// pack_scheduler: arbitrates N_CH telemetry sources onto a single 11-byte packer.
// A frame runs IDLE -> LAUNCH -> WAIT_START -> WAIT_DONE -> GAP -> IDLE. LAUNCH
// drives a one-cycle strobe with the winner's packet. WAIT_START waits for the
// packer busy flag to rise and times out after BUSY_TIMEOUT cycles. WAIT_DONE
// waits for busy to fall. GAP holds off the next launch for GAP_CYCLES cycles.
// Optional build macro PACK_SCHED_PRIO0_EN: source 0 gets strict priority, and
// sources 1..N_CH-1 share a round-robin ring. Undefined means one ring for all.
// Every output is a register. BUSY_TIMEOUT must be at least 1.
module pack_scheduler #(
  parameter int N_CH         = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*88-1:0]   req_data,
  output logic [N_CH-1:0]      ack,
  output logic                 pack_valid,
  output logic [87:0]          pack_data,
  input  logic                 pack_busy,
  output logic [2:0]           grant_id,
  output logic                 active,
  output logic                 err_timeout
);

  // One shared counter times both WAIT_START and GAP, so it must reach the larger bound.
  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_GAP        = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           ptr_r;

  logic [N_CH-1:0]      ack_r;
  logic                 pack_valid_r;
  logic [87:0]          pack_data_r;
  logic [2:0]           grant_r;
  logic                 active_r;
  logic                 err_r;

  logic                 launch_s;
  logic                 tmo_s;
  logic [N_CH-1:0]      rr_req_s;
  logic [2*N_CH-1:0]    dbl_s;
  logic [N_CH-1:0]      rot_s;
  logic [2:0]           off_s;
  logic [3:0]           sum_s;
  logic [2:0]           rr_win_s;
  logic [2:0]           win_s;
  logic [3:0]           ptr_inc_s;
  logic [2:0]           ptr_nx_s;
  logic [87:0]          sel_data_s;
  logic [N_CH-1:0]      onehot_s;

  // Winner selection: rotate the request vector so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    rr_req_s = req;
`ifdef PACK_SCHED_PRIO0_EN
    // Source 0 is handled by the strict-priority path and never competes in the ring.
    rr_req_s[0] = 1'b0;
`endif
    dbl_s = {rr_req_s, rr_req_s};
    rot_s = N_CH'(dbl_s >> ptr_r);
    off_s = 3'd0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = 3'(k);
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (sum_s >= 4'(N_CH)) begin
      rr_win_s = 3'(sum_s - 4'(N_CH));
    end else begin
      rr_win_s = sum_s[2:0];
    end
`ifdef PACK_SCHED_PRIO0_EN
    if (req[0]) begin
      win_s = 3'd0;
    end else begin
      win_s = rr_win_s;
    end
`else
    win_s = rr_win_s;
`endif
  end

  // Winner-derived values: its packet, its one-hot ack, and the pointer position after it.
  always_comb begin
    sel_data_s = 88'h0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data_s = sel_data_s | (req_data[i*88 +: 88] & {88{win_s == 3'(i)}});
    end
    onehot_s  = N_CH'(1) << win_s;
    ptr_inc_s = {1'b0, win_s} + 4'd1;
    if (ptr_inc_s >= 4'(N_CH)) begin
      ptr_nx_s = 3'd0;
    end else begin
      ptr_nx_s = ptr_inc_s[2:0];
    end
  end

  // Next-state logic. Also flags the launch edge and the timeout edge for the output registers.
  always_comb begin
    state_nx_s = state_r;
    launch_s   = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          state_nx_s = ST_LAUNCH;
          launch_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_nx_s = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (pack_busy) begin
          state_nx_s = ST_WAIT_DONE;
        end else if (cnt_r >= TMO_LAST) begin
          tmo_s      = 1'b1;
          state_nx_s = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_nx_s = ST_WAIT_START;
        end
      end
      ST_WAIT_DONE: begin
        if (!pack_busy) begin
          state_nx_s = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_nx_s = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (cnt_r >= GAP_LAST) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_GAP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Dwell counter: restarts on every state change and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_nx_s != state_r) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_SAT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Launch-side registers. Packet, grant and pointer update only at the selection edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= 3'd0;
      pack_data_r  <= 88'h0;
      grant_r      <= 3'd0;
      pack_valid_r <= 1'b0;
      ack_r        <= '0;
    end else begin
      pack_valid_r <= launch_s;
      ack_r        <= launch_s ? onehot_s : '0;
      if (launch_s) begin
        ptr_r       <= ptr_nx_s;
        pack_data_r <= sel_data_s;
        grant_r     <= win_s;
      end else begin
        ptr_r       <= ptr_r;
        pack_data_r <= pack_data_r;
        grant_r     <= grant_r;
      end
    end
  end

  // Status registers, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      active_r <= (state_nx_s != ST_IDLE);
      err_r    <= tmo_s;
    end
  end

  assign ack         = ack_r;
  assign pack_valid  = pack_valid_r;
  assign pack_data   = pack_data_r;
  assign grant_id    = grant_r;
  assign active      = active_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_pack_scheduler.sv
// Directed testbench for pack_scheduler (default build; the strict-priority
// section is compiled only when PACK_SCHED_PRIO0_EN is defined).
module tb_pack_scheduler;

  localparam int N_CH = 4;
  localparam int GAPC = 2;
  localparam int BTMO = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CH-1:0]      req;
  logic [N_CH*88-1:0]   req_data;
  logic [N_CH-1:0]      ack;
  logic                 pack_valid;
  logic [87:0]          pack_data;
  logic                 pack_busy;
  logic [2:0]           grant_id;
  logic                 active;
  logic                 err_timeout;

  logic [87:0] src_data [N_CH];
  int n_cmp = 0;
  int n_err = 0;

  pack_scheduler #(.N_CH(N_CH), .GAP_CYCLES(GAPC), .BUSY_TIMEOUT(BTMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .pack_valid(pack_valid), .pack_data(pack_data), .pack_busy(pack_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [87:0] got, input logic [87:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ticks until pack_valid is seen; returns the number of ticks, or -1 if the budget runs out.
  task automatic wait_launch(input int budget, output int cyc);
    cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (pack_valid && (cyc < 0)) begin
        cyc = n;
        break;
      end
    end
  endtask

  // Packer model: busy rises rise ticks after the launch and stays high for len ticks.
  task automatic serve(input int rise, input int len);
    repeat (rise) tick();
    pack_busy = 1'b1;
    repeat (len) tick();
    pack_busy = 1'b0;
  endtask

  task automatic check_launch(input string tag, input int src);
    logic [N_CH-1:0] oh;
    oh = '0;
    oh[src] = 1'b1;
    check_eq({tag, "_valid"}, 88'(pack_valid), 88'd1);
    check_eq({tag, "_gnt"}, 88'(grant_id), 88'(src));
    check_eq({tag, "_ack"}, 88'(ack), 88'(oh));
    check_eq({tag, "_data"}, pack_data, src_data[src]);
  endtask

  int cyc;
  int nv;
  int na;
  int rise_t [5] = '{2, 3, 5, 2, 4};
  int len_t  [5] = '{3, 1, 6, 2, 4};
  int gnt_t  [5] = '{0, 1, 2, 3, 0};

  initial begin
    src_data[0] = 88'hA0A1A2A3A4A5A6A7A8A9AA;
    src_data[1] = 88'hB0B1B2B3B4B5B6B7B8B9BA;
    src_data[2] = 88'h0A090807060504030201_00;
    src_data[3] = 88'hD0D1D2D3D4D5D6D7D8D9DA;
    req_data = {src_data[3], src_data[2], src_data[1], src_data[0]};
    rst = 1'b1;
    req = 4'b0000;
    pack_busy = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_ack", 88'(ack), 88'd0);
    check_eq("rst_valid", 88'(pack_valid), 88'd0);
    check_eq("rst_data", pack_data, 88'h0);
    check_eq("rst_gnt", 88'(grant_id), 88'd0);
    check_eq("rst_active", 88'(active), 88'd0);
    check_eq("rst_err", 88'(err_timeout), 88'd0);
    rst = 1'b0;

    // Single request from source 2, launched one cycle after selection
    req = 4'b0100;
    tick();
    check_launch("single", 2);
    check_eq("single_active", 88'(active), 88'd1);
    req = 4'b0000;
    tick();
    check_eq("single_valid_drop", 88'(pack_valid), 88'd0);
    check_eq("single_ack_drop", 88'(ack), 88'd0);
    check_eq("single_data_hold", pack_data, src_data[2]);
    serve(1, 3);
    tick();
    tick();
    check_eq("single_gap_active", 88'(active), 88'd1);
    tick();
    check_eq("single_idle", 88'(active), 88'd0);
    check_eq("single_gnt_hold", 88'(grant_id), 88'd2);

    // Round robin with all sources requesting, starting from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_launch(40, cyc);
      check_eq($sformatf("rr%0d_lat", i), 88'(cyc), 88'((i == 0) ? 1 : GAPC + 2));
      check_launch($sformatf("rr%0d", i), gnt_t[i]);
      serve(rise_t[i], len_t[i]);
    end
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Busy never rises: timeout after BUSY_TIMEOUT cycles in WAIT_START, then GAP, then IDLE
    req = 4'b0010;
    wait_launch(4, cyc);
    check_eq("tmo_lat", 88'(cyc), 88'd1);
    check_eq("tmo_gnt", 88'(grant_id), 88'd1);
    req = 4'b0000;
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (err_timeout && (cyc < 0)) begin
        cyc = n;
        break;
      end
    end
    check_eq("tmo_delay", 88'(cyc), 88'(BTMO + 1));
    tick();
    check_eq("tmo_pulse_end", 88'(err_timeout), 88'd0);
    check_eq("tmo_gap_active", 88'(active), 88'd1);
    tick();
    check_eq("tmo_idle", 88'(active), 88'd0);

    // Reset while in WAIT_DONE; pointer sits at 2 after the last grant to 1
    req = 4'b1010;
    wait_launch(4, cyc);
    check_launch("wd", 3);
    tick();
    pack_busy = 1'b1;
    tick();
    tick();
    check_eq("wd_active", 88'(active), 88'd1);
    rst = 1'b1;
    pack_busy = 1'b0;
    tick();
    check_eq("wdrst_ack", 88'(ack), 88'd0);
    check_eq("wdrst_valid", 88'(pack_valid), 88'd0);
    check_eq("wdrst_data", pack_data, 88'h0);
    check_eq("wdrst_gnt", 88'(grant_id), 88'd0);
    check_eq("wdrst_active", 88'(active), 88'd0);
    check_eq("wdrst_err", 88'(err_timeout), 88'd0);
    rst = 1'b0;
    tick();
    check_launch("post_rst", 1);
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Request pulsed only during WAIT_DONE is never granted
    req = 4'b0001;
    wait_launch(4, cyc);
    check_launch("pulse_first", 0);
    req = 4'b0000;
    tick();
    pack_busy = 1'b1;
    tick();
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    pack_busy = 1'b0;
    nv = 0;
    na = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      nv += int'(pack_valid);
      na += int'(|ack);
    end
    check_eq("pulse_no_valid", 88'(nv), 88'd0);
    check_eq("pulse_no_ack", 88'(na), 88'd0);
    check_eq("pulse_idle", 88'(active), 88'd0);

`ifdef PACK_SCHED_PRIO0_EN
    // Strict priority for source 0, then ring among 1..3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wait_launch(40, cyc);
      check_launch($sformatf("prio%0d", i), 0);
      serve(2, 2);
    end
    req = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      wait_launch(40, cyc);
      check_launch($sformatf("ring%0d", i), (i % 3) + 1);
      serve(2, 2);
    end
    req = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
